// File: rtl/smag_mac_acc.sv
// Streaming sign-magnitude multiply-accumulate: per-lane products of activation and weight,
// accumulated with saturation over a packet and reported on the last beat.
module smag_mac_acc #(
    parameter int ACC_W = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [1:0]           convtype,
    input  logic [7:0]           a_mag,
    input  logic [3:0]           a_sign,
    input  logic [7:0]           w_mag,
    input  logic [3:0]           w_sign,
    output logic                 out_valid,
    output logic [4*ACC_W-1:0]   out_acc,
    output logic [3:0]           out_ovf
);

    typedef logic signed [15:0] prod_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Unsigned magnitude product, negated when the signs differ; zero stays zero.
    function automatic prod_t signed_prod(input logic [7:0] ma, input logic [7:0] mw, input logic neg);
        logic [15:0] p;
        p = 16'(ma) * 16'(mw);
        if (neg) begin
            signed_prod = prod_t'(16'd0 - p);
        end else begin
            signed_prod = prod_t'(p);
        end
    endfunction

    logic                pkt_open_r;
    logic [1:0]          mode_r;
    logic                b0_valid_r, b0_last_r, b0_first_r;
    logic [1:0]          b0_mode_r;
    logic [7:0]          b0_a_mag_r, b0_w_mag_r;
    logic [3:0]          b0_neg_r;
    logic                first_s;
    logic [1:0]          eff_mode_s;

    logic [7:0]          ma_s [4];
    logic [7:0]          mw_s [4];
    prod_t               prod_s [4];
    logic                s1_valid_r, s1_last_r, s1_first_r;
    prod_t               s1_prod_r [4];

    logic [ACC_W-1:0]    acc_r [4];
    logic [3:0]          ovf_r;
    logic [ACC_W-1:0]    base_s [4];
    logic [3:0]          ovf_base_s;
    logic [ACC_W:0]      sum_s [4];
    logic [ACC_W-1:0]    acc_nxt_s [4];
    logic [3:0]          ovf_nxt_s;

    // Packet mode is taken from convtype only on the first beat of a packet.
    always_comb begin
        first_s = ~pkt_open_r;
        if (first_s) begin
            eff_mode_s = convtype;
        end else begin
            eff_mode_s = mode_r;
        end
    end

    // Beat capture and packet framing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_open_r <= 1'b0;
            mode_r     <= 2'd0;
            b0_valid_r <= 1'b0;
            b0_last_r  <= 1'b0;
            b0_first_r <= 1'b0;
            b0_mode_r  <= 2'd0;
            b0_a_mag_r <= 8'd0;
            b0_w_mag_r <= 8'd0;
            b0_neg_r   <= 4'd0;
        end else begin
            b0_valid_r <= in_valid;
            if (in_valid) begin
                b0_last_r  <= in_last;
                b0_first_r <= first_s;
                b0_mode_r  <= eff_mode_s;
                b0_a_mag_r <= a_mag;
                b0_w_mag_r <= w_mag;
                b0_neg_r   <= a_sign ^ w_sign;
                mode_r     <= eff_mode_s;
                pkt_open_r <= ~in_last;
            end else begin
                pkt_open_r <= pkt_open_r;
            end
        end
    end

    // Route lane magnitudes to slots; unused slots see zero magnitude.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ma_s[k] = 8'd0;
            mw_s[k] = 8'd0;
        end
        case (b0_mode_r)
            2'b11: begin
                ma_s[3] = b0_a_mag_r;
                mw_s[3] = b0_w_mag_r;
            end
            2'b10: begin
                ma_s[3] = {4'd0, b0_a_mag_r[7:4]};
                mw_s[3] = {4'd0, b0_w_mag_r[7:4]};
                ma_s[1] = {4'd0, b0_a_mag_r[3:0]};
                mw_s[1] = {4'd0, b0_w_mag_r[3:0]};
            end
            default: begin
                for (int k = 0; k < 4; k++) begin
                    ma_s[k] = {6'd0, b0_a_mag_r[2*k +: 2]};
                    mw_s[k] = {6'd0, b0_w_mag_r[2*k +: 2]};
                end
            end
        endcase
        for (int k = 0; k < 4; k++) begin
            prod_s[k] = signed_prod(ma_s[k], mw_s[k], b0_neg_r[k]);
        end
    end

    // Stage 1: registered signed products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_first_r <= 1'b0;
            for (int k = 0; k < 4; k++) s1_prod_r[k] <= 16'sd0;
        end else begin
            s1_valid_r <= b0_valid_r;
            if (b0_valid_r) begin
                s1_last_r  <= b0_last_r;
                s1_first_r <= b0_first_r;
                for (int k = 0; k < 4; k++) s1_prod_r[k] <= prod_s[k];
            end else begin
                s1_last_r  <= s1_last_r;
            end
        end
    end

    // Saturating accumulate; the first beat of a packet restarts from zero.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (s1_first_r) begin
                base_s[k]     = {ACC_W{1'b0}};
                ovf_base_s[k] = 1'b0;
            end else begin
                base_s[k]     = acc_r[k];
                ovf_base_s[k] = ovf_r[k];
            end
            sum_s[k] = {base_s[k][ACC_W-1], base_s[k]}
                     + {{(ACC_W-15){s1_prod_r[k][15]}}, s1_prod_r[k]};
            if (sum_s[k][ACC_W] != sum_s[k][ACC_W-1]) begin
                acc_nxt_s[k] = sum_s[k][ACC_W] ? ACC_MIN : ACC_MAX;
                ovf_nxt_s[k] = 1'b1;
            end else begin
                acc_nxt_s[k] = sum_s[k][ACC_W-1:0];
                ovf_nxt_s[k] = ovf_base_s[k];
            end
        end
    end

    // Stage 2: accumulators and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) acc_r[k] <= {ACC_W{1'b0}};
            ovf_r     <= 4'd0;
            out_valid <= 1'b0;
            out_acc   <= {(4*ACC_W){1'b0}};
            out_ovf   <= 4'd0;
        end else begin
            out_valid <= s1_valid_r & s1_last_r;
            if (s1_valid_r) begin
                for (int k = 0; k < 4; k++) acc_r[k] <= acc_nxt_s[k];
                ovf_r <= ovf_nxt_s;
                if (s1_last_r) begin
                    for (int k = 0; k < 4; k++) out_acc[k*ACC_W +: ACC_W] <= acc_nxt_s[k];
                    out_ovf <= ovf_nxt_s;
                end else begin
                    out_ovf <= out_ovf;
                end
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_smag_mac_acc.sv
// Randomized and directed bench for smag_mac_acc with a packet-level reference model,
// run against a 20-bit and a 16-bit accumulator instance in parallel.
module tb_smag_mac_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [1:0]  convtype = 2'd0;
    logic [7:0]  a_mag = 8'd0, w_mag = 8'd0;
    logic [3:0]  a_sign = 4'd0, w_sign = 4'd0;
    logic        ov20, ov16;
    logic [79:0] acc20;
    logic [63:0] acc16;
    logic [3:0]  ovf20, ovf16;

    smag_mac_acc #(.ACC_W(20)) u20 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .convtype(convtype), .a_mag(a_mag), .a_sign(a_sign), .w_mag(w_mag), .w_sign(w_sign),
        .out_valid(ov20), .out_acc(acc20), .out_ovf(ovf20));
    smag_mac_acc #(.ACC_W(16)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .convtype(convtype), .a_mag(a_mag), .a_sign(a_sign), .w_mag(w_mag), .w_sign(w_sign),
        .out_valid(ov16), .out_acc(acc16), .out_ovf(ovf16));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [79:0] a20;
        logic [63:0] a16;
        logic [3:0]  o20;
        logic [3:0]  o16;
    } res_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          open = 1'b0;
    int          mode = 0;
    int          m20 [4];
    int          m16 [4];
    bit          mo20 [4];
    bit          mo16 [4];
    res_t        q [$];
    logic [79:0] exp_a20 = 80'd0;
    logic [63:0] exp_a16 = 64'd0;
    logic [3:0]  exp_o20 = 4'd0, exp_o16 = 4'd0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int satw(input int v, input int w, output bit hit);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        hit = 1'b1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        hit = 1'b0;
        return v;
    endfunction

    function automatic int lane_prod(input int md, input int k, input logic [7:0] am, input logic [7:0] wm,
                                     input logic [3:0] as, input logic [3:0] ws);
        int ma, mw, p;
        ma = 0;
        mw = 0;
        if (md == 3) begin
            if (k == 3) begin ma = am; mw = wm; end
        end else if (md == 2) begin
            if (k == 3) begin ma = am[7:4]; mw = wm[7:4]; end
            if (k == 1) begin ma = am[3:0]; mw = wm[3:0]; end
        end else begin
            ma = (am >> (2 * k)) & 3;
            mw = (wm >> (2 * k)) & 3;
        end
        p = ma * mw;
        return (as[k] ^ ws[k]) ? -p : p;
    endfunction

    function automatic logic [7:0] gen_mag(input int md);
        logic [7:0] m;
        if (md == 3) m = 8'($urandom_range(0, 128));
        else if (md == 2) m = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 8))};
        else m = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
        return m;
    endfunction

    task automatic model_beat(input bit l, input logic [1:0] ct, input logic [7:0] am, input logic [3:0] as,
                              input logic [7:0] wm, input logic [3:0] ws);
        bit first, hit;
        int p;
        res_t r;
        first = !open;
        if (first) mode = int'(ct);
        for (int k = 0; k < 4; k++) begin
            p = lane_prod(mode, k, am, wm, as, ws);
            if (first) begin
                m20[k] = satw(p, 20, hit); mo20[k] = hit;
                m16[k] = satw(p, 16, hit); mo16[k] = hit;
            end else begin
                m20[k] = satw(m20[k] + p, 20, hit); mo20[k] = mo20[k] | hit;
                m16[k] = satw(m16[k] + p, 16, hit); mo16[k] = mo16[k] | hit;
            end
        end
        open = !l;
        if (l) begin
            r.due = cyc + 2;
            for (int k = 0; k < 4; k++) begin
                r.a20[k*20 +: 20] = m20[k][19:0];
                r.a16[k*16 +: 16] = m16[k][15:0];
                r.o20[k] = mo20[k];
                r.o16[k] = mo16[k];
            end
            q.push_back(r);
        end
    endtask

    task automatic check_outputs();
        bit due_now;
        due_now = (q.size() > 0) && (q[0].due == cyc);
        chk("valid20", 80'(ov20), 80'(due_now));
        chk("valid16", 80'(ov16), 80'(due_now));
        if (due_now) begin
            exp_a20 = q[0].a20; exp_a16 = q[0].a16;
            exp_o20 = q[0].o20; exp_o16 = q[0].o16;
            void'(q.pop_front());
        end
        chk("acc20", acc20, exp_a20);
        chk("acc16", 80'(acc16), 80'(exp_a16));
        chk("ovf20", 80'(ovf20), 80'(exp_o20));
        chk("ovf16", 80'(ovf16), 80'(exp_o16));
    endtask

    task automatic step(input bit v, input bit l, input logic [1:0] ct, input logic [7:0] am,
                        input logic [3:0] as, input logic [7:0] wm, input logic [3:0] ws);
        in_valid = v; in_last = l; convtype = ct;
        a_mag = am; a_sign = as; w_mag = wm; w_sign = ws;
        @(posedge clk);
        cyc++;
        #1;
        if (v) model_beat(l, ct, am, as, wm, ws);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                          8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_v20"}, 80'(ov20), 80'd0);
        chk({tag, "_v16"}, 80'(ov16), 80'd0);
        chk({tag, "_a20"}, acc20, 80'd0);
        chk({tag, "_a16"}, 80'(acc16), 80'd0);
        chk({tag, "_o20"}, 80'(ovf20), 80'd0);
        chk({tag, "_o16"}, 80'(ovf16), 80'd0);
    endtask

    task automatic hard_reset();
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("rst");
        open = 1'b0;
        q.delete();
        exp_a20 = 80'd0; exp_a16 = 64'd0; exp_o20 = 4'd0; exp_o16 = 4'd0;
        @(posedge clk);
        cyc++;
        #1;
        check_all_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        int len, pmode;
        logic [1:0] ct;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("init");
        rst_n = 1'b1;

        // Sign handling and latency
        step(1'b1, 1'b1, 2'b11, 8'd3, 4'b1000, 8'd5, 4'b0000);
        idle(3);
        chk("t1_slot3", 80'(acc20[79:60]), 80'(20'hFFFF1));
        chk("t1_low", 80'(acc20[59:0]), 80'd0);

        // Full-scale magnitude with bubbles
        step(1'b1, 1'b0, 2'b11, 8'h80, 4'b1111, 8'h80, 4'b1111);
        idle(1);
        step(1'b1, 1'b0, 2'b11, 8'h80, 4'b1111, 8'h80, 4'b1111);
        idle(2);
        step(1'b1, 1'b1, 2'b11, 8'h80, 4'b1111, 8'h80, 4'b1111);
        idle(4);
        chk("t2_slot3", 80'(acc20[79:60]), 80'(20'h0C000));

        // 2-bit lanes
        step(1'b1, 1'b1, 2'b00, 8'b01_10_00_01, 4'b0100, 8'b10_01_01_10, 4'b0001);
        idle(3);
        chk("t3_slots", acc20, {20'd2, 20'hFFFFE, 20'd0, 20'hFFFFE});

        // Saturation on the 16-bit instance, then recovery
        step(1'b1, 1'b0, 2'b11, 8'h80, 4'b0000, 8'h80, 4'b0000);
        step(1'b1, 1'b1, 2'b11, 8'h80, 4'b0000, 8'h80, 4'b0000);
        idle(3);
        chk("t4_sat", 80'(acc16[63:48]), 80'(16'h7FFF));
        chk("t4_ovf", 80'(ovf16), 80'(4'b1000));
        step(1'b1, 1'b1, 2'b11, 8'd1, 4'b0000, 8'd1, 4'b0000);
        idle(3);
        chk("t4_next", 80'(acc16[63:48]), 80'(16'd1));
        chk("t4_next_ovf", 80'(ovf16), 80'd0);

        // Back-to-back packets, convtype toggled mid-packet
        step(1'b1, 1'b0, 2'b10, {4'd2, 4'd0}, 4'b0000, {4'd3, 4'd0}, 4'b0000);
        step(1'b1, 1'b1, 2'b11, {4'd7, 4'd0}, 4'b0000, {4'd8, 4'd0}, 4'b1000);
        step(1'b1, 1'b1, 2'b11, 8'd1, 4'b0000, 8'd1, 4'b0000);
        idle(1);
        chk("t5_a", 80'(acc20[79:60]), 80'(20'hFFFCE));
        idle(1);
        chk("t5_b", 80'(acc20[79:60]), 80'(20'd1));
        idle(2);

        // Reset mid-packet
        step(1'b1, 1'b0, 2'b11, 8'd9, 4'b0000, 8'd9, 4'b0000);
        step(1'b1, 1'b0, 2'b11, 8'd9, 4'b0000, 8'd9, 4'b0000);
        hard_reset();
        idle(3);
        step(1'b1, 1'b1, 2'b11, 8'd2, 4'b0000, 8'd2, 4'b0000);
        idle(3);
        chk("t6_slot3", 80'(acc20[79:60]), 80'(20'd4));

        // Random packets with random bubbles and mid-packet convtype noise
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 5);
            pmode = 0;
            for (int b = 0; b < len; b++) begin
                ct = 2'($urandom_range(0, 3));
                if (b == 0) pmode = int'(ct);
                if ($urandom_range(0, 3) == 0) idle(1);
                step(1'b1, (b == len - 1), ct, gen_mag(pmode), 4'($urandom), gen_mag(pmode), 4'($urandom));
            end
        end
        idle(4);
        chk("queue_empty", 80'(q.size()), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/smag_mac_acc.md
Name: smag_mac_acc

Overview:
- Streaming multiply-accumulate stage that sits directly downstream of the signed-to-sign-magnitude converter.
- Takes two sign-magnitude operand words (activation and weight) using the converter's packing: one 8-bit lane, two 4-bit lanes or four 2-bit lanes, selected by convtype.
- Per lane, it multiplies magnitudes, applies the XOR of the two signs and accumulates the signed product over a packet.
- On the last beat it emits the per-lane two's-complement sums with saturation flags.

Parameters:
ACC_W, 20, width of each per-lane signed accumulator; legal range 16..32.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  beat qualifier
in_last  input  1  final beat of packet; meaningful only with in_valid
convtype  input  2  00/01 = 2-bit lanes, 10 = 4-bit lanes, 11 = 8-bit lane
a_mag  input  8  activation magnitudes, lane-packed
a_sign  input  4  activation signs; [3]=lane 7:6/7:4/7:0, [2]=5:4, [1]=3:2/3:0, [0]=1:0
w_mag  input  8  weight magnitudes, same packing
w_sign  input  4  weight signs, same mapping
out_valid  output  1  one-cycle pulse, result valid
out_acc  output  4*ACC_W  slot k at [k*ACC_W +: ACC_W], signed two's complement
out_ovf  output  4  per-slot sticky saturation flag for the packet just reported

Behaviour:
Reset:
- rst_n low immediately clears all pipeline registers, accumulators, packet state, out_valid, out_acc and out_ovf to 0.
- The next accepted beat is treated as the first beat of a new packet.
- A reset asserted mid-packet discards the partial packet; no out_valid is produced for it.

Lane/slot mapping (matches the sign vector):
- 8-bit mode: magnitude 0..128, unsigned. It goes to slot 3 and uses sign[3]. Slots 2..0 stay 0.
- 4-bit mode: magnitude 0..8. [7:4] goes to slot 3 with sign[3]; [3:0] goes to slot 1 with sign[1]. Slots 2 and 0 stay 0.
- 2-bit mode: magnitude 0..2. [7:6]→slot 3, [5:4]→slot 2, [3:2]→slot 1, [1:0]→slot 0, each with the sign bit of the same index.
- Magnitude bits are treated as unsigned. 8'h80 means 128.

Stage 1 (edge after an accepted beat):
- For each active slot, register prod = mag_a*mag_w as a 16-bit signed value.
- Negate it when a_sign^w_sign = 1.
- A zero magnitude always yields 0; there is no negative zero.
- Also register valid, last, first and the packet mode.

Stage 2 (next edge):
- first: acc = prod.
- Otherwise: acc = sat(acc + prod).
- sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Clamping sets that slot's sticky ovf.
- ovf clears on the first beat of each packet.

Packet mode:
- convtype is latched on the first beat of a packet and used for every beat of that packet.
- A convtype change mid-packet is ignored until the next packet.

Output:
- When stage 2 processes a last beat, on that same edge out_acc and out_ovf load the final accumulator values and out_valid goes high for exactly one cycle.
- Latency: a last beat sampled at edge T gives out_valid=1 between edges T+2 and T+3.
- out_acc and out_ovf hold their values until the next result.

Streaming:
- There is no backpressure; one beat is accepted per cycle.
- in_valid=0 bubbles anywhere leave the accumulators untouched.
- A beat with in_last=1 immediately followed by a new beat: the new beat starts a fresh packet, and back-to-back packets never mix.
- A single-beat packet (first and last together) yields acc = prod.

Widths:
- Max |prod| is 16384.
- For ACC_W=20, saturation needs more than 31 consecutive full-scale beats.

Test Plan:
1. Sign handling and latency:
   - Stimulus: 8-bit mode, a_mag=3 with a_sign=4'b1000, w_mag=5 with w_sign=0, single beat with last.
   - Response: out_valid exactly 2 cycles later; slot3 = -15 (20'hFFFF1); slots 2..0 = 0; ovf = 0.
2. Full-scale magnitude:
   - Stimulus: 8-bit mode, a_mag=w_mag=8'h80, both signs 1, 3-beat packet with in_valid bubbles between beats.
   - Response: slot3 = +49152; a single out_valid pulse.
3. 2-bit lanes:
   - Stimulus: a_mag=8'b01_10_00_01, a_sign=4'b0100, w_mag=8'b10_01_01_10, w_sign=4'b0001, single beat.
   - Response: slot3 = +2, slot2 = -2, slot1 = 0, slot0 = -2.
4. Saturation:
   - Stimulus: ACC_W=16, 8-bit mode, two beats of 128*128 with positive product.
   - Response: slot3 = 32767, out_ovf = 4'b1000.
   - Follow-up: the next packet of 1*1 gives slot3 = 1 and ovf = 0.
5. Back-to-back packets and latched mode:
   - Stimulus: packet A in 4-bit mode (2*3 and 7*-8 over two beats) immediately followed by packet B whose first beat is 8-bit mode 1*1; convtype toggled mid-packet on A's second beat.
   - Response: A reports slot3 = 6 + (-56) = -50 on 4-bit lanes; B reports slot3 = 1; no carry-over between packets.
6. Reset mid-packet:
   - Stimulus: assert rst_n low asynchronously after 2 of 3 beats, release, then send a 1-beat packet 2*2.
   - Response: all outputs 0 during reset; no pulse for the aborted packet; the new packet reports slot3 = 4.
